// File: rtl/uart_iomem_bridge_if.sv
// iomem peripheral bus signal bundle: the bridge drives it as master, a responder as slave.
interface uart_iomem_bridge_if;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    modport master (output m_valid, m_wstrb, m_addr, m_wdata, input m_ready, m_rdata);
    modport slave  (input m_valid, m_wstrb, m_addr, m_wdata, output m_ready, m_rdata);
endinterface

// File: rtl/uart_iomem_bridge.sv
// UART (8N1) debug bridge issuing single 32-bit iomem reads/writes and returning the result over tx.
// state  | meaning
// IDLE   | waiting for a command byte (0x57 write, 0x52 read, else NAK)
// ADDR   | collecting A3..A0
// DATA   | collecting D3..D0 (write only)
// BUS    | m_valid held until m_ready or timeout
// RESP   | sending ACK/NAK or R3..R0 back-to-back
module uart_iomem_bridge #(
    parameter int CLKS_PER_BIT = 139,
    parameter int TIMEOUT      = 1024
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_rx,
    output logic o_tx,
    output logic o_busy,
    uart_iomem_bridge_if.master bus
);
    localparam logic [15:0] LP_BIT  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] LP_HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] LP_TMO  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_BUS, P_RESP} p_state_t;

    logic        r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t   r_rx_state, w_rx_next;
    logic [15:0] r_rx_cnt, w_rx_cnt;
    logic [2:0]  r_rx_bit, w_rx_bit;
    logic [7:0]  r_rx_sh, w_rx_sh;
    logic        w_rx_done, w_rx_ferr;

    p_state_t    r_p_state, w_p_next;
    logic        r_is_wr, w_is_wr;
    logic [31:0] r_addr, w_addr, r_wdata, w_wdata, r_resp, w_resp;
    logic [1:0]  r_nbyte, w_nbyte;
    logic        r_valid, w_valid;
    logic [15:0] r_tmo, w_tmo;
    logic [2:0]  r_resp_n, w_resp_n;

    logic        r_tx, r_tx_act;
    logic [8:0]  r_tx_sh;
    logic [3:0]  r_tx_left;
    logic [15:0] r_tx_cnt;
    logic        w_tx_done, w_tx_load;

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_cnt  = r_rx_cnt;
        w_rx_bit  = r_rx_bit;
        w_rx_sh   = r_rx_sh;
        w_rx_done = 1'b0;
        w_rx_ferr = 1'b0;
        case (r_rx_state)
            RX_HUNT: if (r_rx_prev && !r_rx_sync) begin
                w_rx_next = RX_START;
                w_rx_cnt  = LP_HALF;
            end
            RX_START: if (r_rx_cnt == '0) begin
                if (!r_rx_sync) begin
                    w_rx_next = RX_DATA;
                    w_rx_cnt  = LP_BIT;
                    w_rx_bit  = '0;
                end else begin
                    w_rx_next = RX_HUNT;
                end
            end else w_rx_cnt = r_rx_cnt - 16'd1;
            RX_DATA: if (r_rx_cnt == '0) begin
                w_rx_sh  = {r_rx_sync, r_rx_sh[7:1]};
                w_rx_cnt = LP_BIT;
                if (r_rx_bit == 3'd7) w_rx_next = RX_STOP;
                else                  w_rx_bit  = r_rx_bit + 3'd1;
            end else w_rx_cnt = r_rx_cnt - 16'd1;
            RX_STOP: if (r_rx_cnt == '0) begin
                w_rx_next = RX_HUNT;
                w_rx_done = r_rx_sync;
                w_rx_ferr = !r_rx_sync;
            end else w_rx_cnt = r_rx_cnt - 16'd1;
            default: w_rx_next = RX_HUNT;
        endcase
    end

    // Next reply byte may start in the very cycle the previous stop bit ends.
    assign w_tx_done = r_tx_act && (r_tx_cnt == '0) && (r_tx_left == '0);
    assign w_tx_load = (r_p_state == P_RESP) && (r_resp_n != '0) && (!r_tx_act || w_tx_done);

    always_comb begin
        w_p_next = r_p_state;
        w_is_wr  = r_is_wr;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_nbyte  = r_nbyte;
        w_valid  = r_valid;
        w_tmo    = r_tmo;
        w_resp   = r_resp;
        w_resp_n = r_resp_n;
        case (r_p_state)
            P_IDLE: if (w_rx_done) begin
                if (r_rx_sh == 8'h57 || r_rx_sh == 8'h52) begin
                    w_p_next = P_ADDR;
                    w_is_wr  = (r_rx_sh == 8'h57);
                    w_nbyte  = 2'd3;
                end else begin
                    w_p_next = P_RESP;
                    w_resp   = {8'h15, 24'h0};
                    w_resp_n = 3'd1;
                end
            end
            P_ADDR: if (w_rx_ferr) w_p_next = P_IDLE;
            else if (w_rx_done) begin
                w_addr = {r_addr[23:0], r_rx_sh};
                if (r_nbyte != '0) w_nbyte = r_nbyte - 2'd1;
                else if (r_is_wr) begin
                    w_p_next = P_DATA;
                    w_nbyte  = 2'd3;
                end else begin
                    w_p_next = P_BUS;
                    w_valid  = 1'b1;
                    w_tmo    = LP_TMO;
                end
            end
            P_DATA: if (w_rx_ferr) w_p_next = P_IDLE;
            else if (w_rx_done) begin
                w_wdata = {r_wdata[23:0], r_rx_sh};
                if (r_nbyte != '0) w_nbyte = r_nbyte - 2'd1;
                else begin
                    w_p_next = P_BUS;
                    w_valid  = 1'b1;
                    w_tmo    = LP_TMO;
                end
            end
            P_BUS: if (bus.m_ready) begin
                w_valid  = 1'b0;
                w_p_next = P_RESP;
                w_resp   = r_is_wr ? {8'h06, 24'h0} : bus.m_rdata;
                w_resp_n = r_is_wr ? 3'd1 : 3'd4;
            end else if (r_tmo == '0) begin
                w_valid  = 1'b0;
                w_p_next = P_RESP;
                w_resp   = {8'h15, 24'h0};
                w_resp_n = 3'd1;
            end else w_tmo = r_tmo - 16'd1;
            P_RESP: if (w_tx_load) begin
                w_resp   = {r_resp[23:0], 8'h0};
                w_resp_n = r_resp_n - 3'd1;
            end else if (r_resp_n == '0 && w_tx_done) w_p_next = P_IDLE;
            default: w_p_next = P_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_HUNT;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
            r_p_state  <= P_IDLE;
            r_is_wr    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_nbyte    <= '0;
            r_valid    <= 1'b0;
            r_tmo      <= '0;
            r_resp     <= '0;
            r_resp_n   <= '0;
        end else begin
            r_rx_meta  <= i_rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_next;
            r_rx_cnt   <= w_rx_cnt;
            r_rx_bit   <= w_rx_bit;
            r_rx_sh    <= w_rx_sh;
            r_p_state  <= w_p_next;
            r_is_wr    <= w_is_wr;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_nbyte    <= w_nbyte;
            r_valid    <= w_valid;
            r_tmo      <= w_tmo;
            r_resp     <= w_resp;
            r_resp_n   <= w_resp_n;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_tx      <= 1'b1;
            r_tx_act  <= 1'b0;
            r_tx_sh   <= '0;
            r_tx_left <= '0;
            r_tx_cnt  <= '0;
        end else if (w_tx_load) begin
            r_tx      <= 1'b0;
            r_tx_act  <= 1'b1;
            r_tx_sh   <= {1'b1, r_resp[31:24]};
            r_tx_left <= 4'd9;
            r_tx_cnt  <= LP_BIT;
        end else if (r_tx_act) begin
            if (r_tx_cnt != '0) r_tx_cnt <= r_tx_cnt - 16'd1;
            else if (r_tx_left == '0) r_tx_act <= 1'b0;
            else begin
                r_tx      <= r_tx_sh[0];
                r_tx_sh   <= {1'b0, r_tx_sh[8:1]};
                r_tx_left <= r_tx_left - 4'd1;
                r_tx_cnt  <= LP_BIT;
            end
        end
    end

    assign o_tx        = r_tx;
    assign o_busy      = (r_p_state != P_IDLE);
    assign bus.m_valid = r_valid;
    assign bus.m_addr  = r_addr;
    assign bus.m_wdata = r_wdata;
    assign bus.m_wstrb = {4{r_is_wr}};
endmodule

// File: tb/tb_uart_iomem_bridge.sv
// Directed bench for uart_iomem_bridge: host UART driver, iomem responder, reply scoreboard.
module tb_uart_iomem_bridge;
    localparam int CPB = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic rx = 1'b1;
    logic tx, busy;

    uart_iomem_bridge_if bus();

    logic        ready_hi = 1'b0;
    logic        ready_pulse = 1'b0;
    int          ready_delay = 0;
    logic [31:0] rdata = '0;
    assign bus.m_ready = ready_hi | ready_pulse;
    assign bus.m_rdata = rdata;

    uart_iomem_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_resetn(resetn), .i_rx(rx), .o_tx(tx), .o_busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int exp_total = 0;
    int rx_cnt = 0;

    int pulses = 0, vcyc = 0, last_len = 0, unstable = 0;
    logic vprev = 1'b0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;

    logic mon_prev = 1'b1;
    logic [7:0] mon_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        exp_q.push_back(b);
        exp_total++;
    endtask

    // Responder and bus monitor; ready_pulse rises after ready_delay cycles of m_valid.
    always @(negedge clk) begin
        if (bus.m_valid) begin
            if (!vprev) begin
                pulses++;
                vcyc = 0;
                cap_addr = bus.m_addr;
                cap_wdata = bus.m_wdata;
                cap_wstrb = bus.m_wstrb;
            end else if (bus.m_addr !== cap_addr || bus.m_wdata !== cap_wdata ||
                         bus.m_wstrb !== cap_wstrb) begin
                unstable++;
            end
            vcyc++;
            ready_pulse = (ready_delay != 0 && vcyc == ready_delay);
        end else begin
            if (vprev) last_len = vcyc;
            ready_pulse = 1'b0;
        end
        vprev = bus.m_valid;
    end

    initial begin : tx_monitor
        forever begin
            @(negedge clk);
            if (mon_prev && !tx) begin
                repeat (CPB / 2) @(negedge clk);
                chk("tx_start", 32'(tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                chk("tx_stop", 32'(tx), 32'd1);
                rx_cnt++;
                chk("tx_unexpected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("tx_byte", 32'(mon_b), 32'(exp_q.pop_front()));
            end
            mon_prev = tx;
        end
    end

    task automatic send(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!stop) repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_read(input logic [31:0] a);
        send(8'h52);
        for (int i = 3; i >= 0; i--) send(a[8*i +: 8]);
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        send(8'h57);
        for (int i = 3; i >= 0; i--) send(a[8*i +: 8]);
        for (int i = 3; i >= 0; i--) send(d[8*i +: 8]);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (rx_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("tx_wait", 32'(rx_cnt >= n), 32'd1);
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_tx"},     32'(tx), 32'd1);
        chk({pfx, "_valid"},  32'(bus.m_valid), 32'd0);
        chk({pfx, "_wstrb"},  32'(bus.m_wstrb), 32'd0);
        chk({pfx, "_addr"},   bus.m_addr, 32'd0);
        chk({pfx, "_wdata"},  bus.m_wdata, 32'd0);
        chk({pfx, "_busy"},   32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        ready_hi = 1'b1;
        push(8'h06);
        send_write(32'h03000004, 32'h00000001);
        wait_tx(exp_total, 2000);
        chk("wr_pulses", 32'(pulses), 32'd1);
        chk("wr_addr", cap_addr, 32'h03000004);
        chk("wr_wdata", cap_wdata, 32'h00000001);
        chk("wr_wstrb", 32'(cap_wstrb), 32'hF);
        chk("wr_len", 32'(last_len), 32'd1);
        chk("wr_busy", 32'(busy), 32'd0);

        ready_hi = 1'b0;
        ready_delay = 5;
        rdata = 32'hDEADBEEF;
        push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF);
        send_read(32'h07000000);
        wait_tx(exp_total, 2000);
        chk("rd_pulses", 32'(pulses), 32'd2);
        chk("rd_addr", cap_addr, 32'h07000000);
        chk("rd_wstrb", 32'(cap_wstrb), 32'h0);
        chk("rd_len", 32'(last_len), 32'd5);

        ready_delay = 0;
        push(8'h15);
        send_read(32'h00000010);
        wait_tx(exp_total, 2000);
        chk("tmo_pulses", 32'(pulses), 32'd3);
        chk("tmo_len", 32'(last_len), 32'd16);

        ready_delay = 2;
        rdata = 32'h12345678;
        push(8'h12); push(8'h34); push(8'h56); push(8'h78);
        send_read(32'h00000020);
        wait_tx(exp_total, 2000);
        chk("rd2_pulses", 32'(pulses), 32'd4);
        chk("rd2_addr", cap_addr, 32'h00000020);

        push(8'h15);
        send(8'hA5);
        wait_tx(exp_total, 2000);
        chk("nak_pulses", 32'(pulses), 32'd4);
        chk("nak_busy", 32'(busy), 32'd0);

        ready_delay = 0;
        ready_hi = 1'b1;
        send(8'h57);
        send(8'h03);
        send(8'h00, 1'b0);
        repeat (8 * CPB) @(negedge clk);
        chk("ferr_busy", 32'(busy), 32'd0);
        chk("ferr_pulses", 32'(pulses), 32'd4);
        push(8'h06);
        send_write(32'h10000008, 32'hCAFEBABE);
        wait_tx(exp_total, 2000);
        chk("ferr_wr_pulses", 32'(pulses), 32'd5);
        chk("ferr_wr_addr", cap_addr, 32'h10000008);
        chk("ferr_wr_wdata", cap_wdata, 32'hCAFEBABE);

        ready_hi = 1'b0;
        ready_delay = 1;
        rdata = 32'hA1B2C3D4;
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
        send_read(32'h07000004);
        send(8'h57);
        wait_tx(exp_total, 2000);
        repeat (20 * CPB) @(negedge clk);
        chk("ovl_pulses", 32'(pulses), 32'd6);
        chk("ovl_busy", 32'(busy), 32'd0);
        chk("ovl_count", 32'(rx_cnt), 32'(exp_total));

        ready_hi = 1'b1;
        ready_delay = 0;
        send(8'h57);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'hAA);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        push(8'h06);
        send_write(32'h0000000C, 32'h11223344);
        wait_tx(exp_total, 2000);
        chk("post_rst_pulses", 32'(pulses), 32'd7);
        chk("post_rst_addr", cap_addr, 32'h0000000C);
        chk("post_rst_wdata", cap_wdata, 32'h11223344);
        chk("post_rst_wstrb", 32'(cap_wstrb), 32'hF);

        chk("addr_stable", 32'(unstable), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("sb_count", 32'(rx_cnt), 32'(exp_total));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_iomem_bridge.md
# uart_iomem_bridge

Serial debug bridge that acts as an initiator on the SoC peripheral bus (iomem). It receives 8N1 command frames on a UART line, issues a single 32-bit read or write on the iomem bus, and returns the result over UART. The bridge lets a host poke peripherals (gpio, audio, video, sdcard, i2c, flash) without firmware running. It drives the same valid/ready/wstrb/addr/wdata/rdata signal set that peripherals answer.

## Interface
- CLKS_PER_BIT, 139, clk cycles per UART bit (16 MHz / 115200); legal range 4..65535
- TIMEOUT, 1024, cycles to wait for m_ready before aborting a bus cycle; legal range 1..65535
- clk  in  1  system clock
- resetn  in  1  reset; one clock, asynchronous assert, active-low
- rx  in  1  UART receive, idle high, asynchronous to clk
- tx  out  1  UART transmit, idle high
- m_valid  out  1  bus request
- m_ready  in  1  responder completion
- m_wstrb  out  4  4'hF for a write, 4'h0 for a read
- m_addr  out  32  byte address
- m_wdata  out  32  write data
- m_rdata  in  32  read data, valid in the cycle m_ready=1
- busy  out  1  high in every state except IDLE

## Operation
- rx passes through a 2-flop synchronizer. The receiver detects the falling edge, re-samples at half a bit (start bit must still read 0, otherwise it returns to hunt), then samples 8 data bits LSB first at bit centres, then the stop bit.
- A stop bit of 0 is a framing error: the byte is discarded and the parser is forced to IDLE.
- Command protocol (multi-byte fields are big-endian, MSB first):
  - Write: 0x57, A3..A0, D3..D0. After the bus cycle the bridge replies 0x06 (ACK).
  - Read: 0x52, A3..A0. After the bus cycle the bridge replies with 4 bytes R3..R0.
  - Any other first byte: the bridge replies 0x15 (NAK) and returns to IDLE.
- Parser states:
  - IDLE → CMD_ADDR on 0x57 or 0x52.
  - CMD_ADDR collects 4 bytes → CMD_DATA (write) or BUS (read).
  - CMD_DATA collects 4 bytes → BUS.
  - BUS → RESP on m_ready or on timeout.
  - RESP sends the reply bytes → IDLE.
- Bytes received while in BUS or RESP are dropped. The receiver keeps running, so no byte is half-captured.
- BUS handshake:
  - m_valid rises on the cycle after the last command byte is accepted.
  - m_addr, m_wdata and m_wstrb are stable from that cycle until m_valid falls.
  - On the first rising edge where m_valid=1 and m_ready=1: m_rdata is captured and m_valid clears, so m_valid is low on the next cycle.
  - m_ready while m_valid=0 is ignored.
- Timeout: a counter starts at 0 when m_valid rises. If it reaches TIMEOUT with no m_ready, m_valid clears and the reply is the single byte 0x15 (for reads and writes alike).
- The address is not checked for alignment; m_addr is presented exactly as received.

## Timing
- Reset values:
  - Outputs: tx=1, m_valid=0, m_wstrb=0, m_addr=0, m_wdata=0, busy=0.
  - Internal: parser IDLE, receiver hunting, transmitter idle.
- Reset asserted mid-operation aborts immediately. m_valid drops asynchronously and tx returns high, which may truncate a byte in flight.
- TX frame: start bit, 8 data bits LSB first, stop bit. Each bit lasts exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles.
- Reply bytes are sent back-to-back with no idle bits between them.
- The first reply start bit begins on the cycle after m_valid falls, or on the cycle after the NAK decision.
- Minimum bus latency is 1 cycle from the last stop-bit sample to m_valid=1. m_ready may be combinational, i.e. high in the same cycle m_valid rises.
- busy rises on the cycle the command byte is accepted and falls on the cycle the last reply stop bit ends.

## Test plan
- Write path (CLKS_PER_BIT=4), host sends 57 03 00 00 04 00 00 00 01, m_ready tied high → exactly one m_valid pulse with m_addr=0x03000004, m_wdata=0x00000001, m_wstrb=4'hF; tx returns 0x06.
- Read path: host sends 52 07 00 00 00; responder raises m_ready 5 cycles after m_valid with m_rdata=0xDEADBEEF → tx returns DE AD BE EF; m_wstrb=0 for the whole cycle.
- Timeout (TIMEOUT=16): read with m_ready held low → m_valid high for exactly 16 cycles, then tx returns 0x15; a subsequent valid read completes normally.
- Bad command and framing error: host sends 0xA5 → tx returns 0x15. A write whose third byte has stop bit 0 → no m_valid is issued, and a following complete write is accepted.
- Overlap and reset: extra byte sent during the RESP phase → dropped, no second bus cycle. resetn pulsed low during CMD_DATA → all outputs at reset values, busy=0, and the next full command works.
